// File: rtl/pipe_ctrl.sv
// pipe_ctrl
//   Pipeline control unit sitting beside the decode stage register of the
//   four-stage controller. Each cycle it decides whether the decoded
//   instruction issues into execute, stalls in decode, or is flushed. It keeps
//   a 16-entry register scoreboard for RAW/WAW hazards, sequences the
//   multi-cycle MUL occupancy of execute, and applies the two-cycle flush that
//   follows a taken branch.
//
// Parameters
//   OP_NOP   no-op opcode: writes nothing, never hazards
//   OP_JMP   jump opcode: reads s1/s2, writes nothing
//   OP_MUL   multi-cycle multiply opcode
//   MUL_LAT  execute cycles occupied by MUL (2..15)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   d_valid       decode register holds a valid instruction
//   d_opcode      decoded opcode
//   d_dest        destination register
//   d_s1, d_s2    source registers
//   wb_valid      writeback retires a register write this cycle
//   wb_dest       register retired
//   branch_taken  execute resolved a taken branch/jump this cycle
//   issue         decode instruction moves into execute at this edge
//   stall_fd      fetch and decode registers hold
//   flush_fd      fetch and decode registers load NOP
//   bubble_x      execute register loads NOP
//   x_hold        execute register holds (MUL in progress)
//   sb_pending    scoreboard, bit r set = write to r outstanding

module pipe_ctrl #(
   parameter logic [4:0]  OP_NOP  = 5'h00,
   parameter logic [4:0]  OP_JMP  = 5'h1F,
   parameter logic [4:0]  OP_MUL  = 5'h0A,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_valid,
   input  logic [4:0]  d_opcode,
   input  logic [3:0]  d_dest,
   input  logic [3:0]  d_s1,
   input  logic [3:0]  d_s2,
   input  logic        wb_valid,
   input  logic [3:0]  wb_dest,
   input  logic        branch_taken,
   output logic        issue,
   output logic        stall_fd,
   output logic        flush_fd,
   output logic        bubble_x,
   output logic        x_hold,
   output logic [15:0] sb_pending
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Issue cycle is not counted by the MUL state, so it runs MUL_LAT-1 cycles.
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        writes, uses_src, hazard;
   logic [15:0] wb_clr, eff, sb_set;

   // Hazard detection. A register retiring this very cycle is already free.
   always_comb begin
      writes   = (d_opcode != OP_NOP) && (d_opcode != OP_JMP);
      uses_src = (d_opcode != OP_NOP);
      wb_clr   = wb_valid ? (16'h0001 << wb_dest) : '0;
      eff      = sb_pending & ~wb_clr;
      hazard   = d_valid & ((uses_src & (eff[d_s1] | eff[d_s2])) |
                            (writes & eff[d_dest]));
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      issue    = 1'b0;
      stall_fd = 1'b0;
      flush_fd = 1'b0;
      bubble_x = 1'b0;
      x_hold   = 1'b0;
      if (reset) begin
         flush_fd = 1'b1;
         bubble_x = 1'b1;
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (branch_taken) begin
                  flush_fd = 1'b1;
                  bubble_x = 1'b1;
                  state_nx = FLUSH;
               end else if (!d_valid) begin
                  bubble_x = 1'b1;
               end else if (hazard) begin
                  stall_fd = 1'b1;
                  bubble_x = 1'b1;
               end else begin
                  issue = 1'b1;
                  if (d_opcode == OP_MUL) begin
                     cnt_nx   = MUL_CNT;
                     state_nx = MUL;
                  end
               end
            end
            MUL: begin
               x_hold   = 1'b1;
               stall_fd = d_valid;
               cnt_nx   = cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state_nx = IDLE;
               end
            end
            FLUSH: begin
               flush_fd = 1'b1;
               bubble_x = 1'b1;
               state_nx = IDLE;
            end
            default: begin
               state_nx = IDLE;
            end
         endcase
      end
   end

   // Set is applied after clear so a same-register collision leaves it set.
   always_comb begin
      sb_set = (issue & writes) ? (16'h0001 << d_dest) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         sb_pending <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         sb_pending <= (sb_pending & ~wb_clr) | sb_set;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl. A cycle-count reference model checks
//   every output on every falling edge; directed sequences pin the model with
//   literal expectations before a randomized phase.

module tb_pipe_ctrl;

   localparam logic [4:0]  OP_NOP  = 5'h00;
   localparam logic [4:0]  OP_JMP  = 5'h1F;
   localparam logic [4:0]  OP_MUL  = 5'h0A;
   localparam logic [4:0]  OP_ADD  = 5'h01;
   localparam int unsigned MUL_LAT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        d_valid = 1'b0;
   logic [4:0]  d_opcode = 5'h00;
   logic [3:0]  d_dest = 4'h0;
   logic [3:0]  d_s1 = 4'h0;
   logic [3:0]  d_s2 = 4'h0;
   logic        wb_valid = 1'b0;
   logic [3:0]  wb_dest = 4'h0;
   logic        branch_taken = 1'b0;
   logic        issue, stall_fd, flush_fd, bubble_x, x_hold;
   logic [15:0] sb_pending;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: outstanding writes and remaining busy cycles.
   bit pend [16];
   int mul_rem   = 0;
   int flush_rem = 0;
   bit model_on  = 1'b0;

   pipe_ctrl #(
      .OP_NOP (OP_NOP),
      .OP_JMP (OP_JMP),
      .OP_MUL (OP_MUL),
      .MUL_LAT(MUL_LAT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .d_valid     (d_valid),
      .d_opcode    (d_opcode),
      .d_dest      (d_dest),
      .d_s1        (d_s1),
      .d_s2        (d_s2),
      .wb_valid    (wb_valid),
      .wb_dest     (wb_dest),
      .branch_taken(branch_taken),
      .issue       (issue),
      .stall_fd    (stall_fd),
      .flush_fd    (flush_fd),
      .bubble_x    (bubble_x),
      .x_hold      (x_hold),
      .sb_pending  (sb_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // Control bits packed as {issue, stall_fd, flush_fd, bubble_x, x_hold}.
   task automatic lit(input string name, input logic [4:0] exp);
      chk(name, 16'({issue, stall_fd, flush_fd, bubble_x, x_hold}), 16'(exp));
   endtask

   task automatic lit_sb(input string name, input logic [15:0] exp);
      chk(name, sb_pending, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [4:0] op, input logic [3:0] dst,
                         input logic [3:0] s1, input logic [3:0] s2);
      d_valid  = v;
      d_opcode = op;
      d_dest   = dst;
      d_s1     = s1;
      d_s2     = s2;
   endtask

   task automatic set_wb(input logic v, input logic [3:0] r);
      wb_valid = v;
      wb_dest  = r;
   endtask

   function automatic bit busy(input logic [3:0] r);
      return pend[r] && !(wb_valid && (wb_dest == r));
   endfunction

   // Compare process: expected outputs from the model, then advance the model.
   initial begin
      logic [4:0]  e;
      logic [15:0] pv;
      bit wr, us, haz, iss;
      wait (model_on);
      forever begin
         @(negedge clk);
         for (int r = 0; r < 16; r++) pv[r] = pend[r];
         chk("model_sb", sb_pending, pv);
         wr  = (d_opcode != OP_NOP) && (d_opcode != OP_JMP);
         us  = (d_opcode != OP_NOP);
         haz = (us && (busy(d_s1) || busy(d_s2))) || (wr && busy(d_dest));
         iss = 1'b0;
         if (reset)                           e = 5'b00110;
         else if (mul_rem > 0)                e = {1'b0, d_valid, 3'b001};
         else if (flush_rem > 0 || branch_taken) e = 5'b00110;
         else if (!d_valid)                   e = 5'b00010;
         else if (haz)                        e = 5'b01010;
         else begin
            e   = 5'b10000;
            iss = 1'b1;
         end
         chk("model_ctrl", 16'({issue, stall_fd, flush_fd, bubble_x, x_hold}), 16'(e));
         if (reset) begin
            for (int r = 0; r < 16; r++) pend[r] = 1'b0;
            mul_rem   = 0;
            flush_rem = 0;
         end else begin
            if (mul_rem > 0)                      mul_rem--;
            else if (flush_rem > 0)               flush_rem--;
            else if (branch_taken)                flush_rem = 1;
            else if (iss && d_opcode == OP_MUL)   mul_rem = MUL_LAT - 1;
            if (wb_valid)  pend[wb_dest] = 1'b0;
            if (iss && wr) pend[d_dest]  = 1'b1;
         end
      end
   end

   initial begin
      int cand [$];
      // Reset
      tick();
      #1;
      lit("reset_ctrl", 5'b00110);
      lit_sb("reset_sb", 16'h0000);
      model_on = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      lit("idle_empty", 5'b00010);

      // RAW on r3, released by same-cycle writeback
      tick(); set_in(1, OP_ADD, 4'd3, 4'd1, 4'd2); #1;
      lit("raw_first_issue", 5'b10000);
      tick(); set_in(1, OP_ADD, 4'd4, 4'd3, 4'd0); #1;
      lit("raw_stall", 5'b01010);
      lit_sb("raw_sb_r3", 16'h0008);
      tick(); set_wb(1, 4'd3); #1;
      lit("raw_release", 5'b10000);
      tick(); set_in(0, OP_NOP, 4'd0, 4'd0, 4'd0); set_wb(0, 4'd0); #1;
      lit_sb("raw_sb_r4", 16'h0010);

      // WAW with set/clear collision on r4
      tick(); set_in(1, OP_ADD, 4'd4, 4'd0, 4'd0); set_wb(1, 4'd4); #1;
      lit("waw_issue", 5'b10000);
      tick(); set_in(0, OP_NOP, 4'd0, 4'd0, 4'd0); set_wb(1, 4'd4); #1;
      lit_sb("waw_set_wins", 16'h0010);
      tick(); set_wb(0, 4'd0); #1;
      lit_sb("waw_cleared", 16'h0000);

      // MUL occupancy; branch during MUL is ignored
      tick(); set_in(1, OP_MUL, 4'd5, 4'd0, 4'd1); #1;
      lit("mul_issue", 5'b10000);
      tick(); set_in(1, OP_ADD, 4'd6, 4'd7, 4'd7); #1;
      lit("mul_hold1", 5'b01001);
      lit_sb("mul_sb", 16'h0020);
      tick(); branch_taken = 1'b1; #1;
      lit("mul_hold2_branch", 5'b01001);
      tick(); branch_taken = 1'b0; #1;
      lit("mul_hold3", 5'b01001);
      tick(); #1;
      lit("mul_next_issue", 5'b10000);

      // Branch flush
      tick(); set_in(1, OP_ADD, 4'd7, 4'd0, 4'd0); branch_taken = 1'b1; #1;
      lit("br_cycle0", 5'b00110);
      tick(); branch_taken = 1'b0; #1;
      lit("br_cycle1", 5'b00110);
      tick(); #1;
      lit("br_issue", 5'b10000);

      // NOP ignores pending sources, JMP does not and writes nothing
      tick(); set_in(1, OP_NOP, 4'd5, 4'd5, 4'd6); #1;
      lit("nop_issue", 5'b10000);
      lit_sb("pre_jmp_sb", 16'h00E0);
      tick(); set_in(1, OP_JMP, 4'd0, 4'd6, 4'd0); #1;
      lit("jmp_stall", 5'b01010);
      tick(); set_wb(1, 4'd6); #1;
      lit("jmp_issue", 5'b10000);
      tick(); set_in(0, OP_NOP, 4'd0, 4'd0, 4'd0); set_wb(1, 4'd5); #1;
      lit_sb("jmp_no_set", 16'h00A0);
      tick(); set_wb(1, 4'd7); #1;
      tick(); set_wb(0, 4'd0); #1;
      lit_sb("drained", 16'h0000);

      // Reset in the middle of a MUL with r3 and r5 pending
      set_in(1, OP_ADD, 4'd3, 4'd0, 4'd0); #1;
      tick(); set_in(1, OP_MUL, 4'd5, 4'd0, 4'd0); #1;
      lit("rst_mul_issue", 5'b10000);
      tick(); set_in(0, OP_NOP, 4'd0, 4'd0, 4'd0); #1;
      lit("rst_in_mul", 5'b00001);
      lit_sb("rst_sb_0028", 16'h0028);
      tick(); reset = 1'b1; #1;
      lit("rst_forced", 5'b00110);
      tick(); #1;
      lit("rst_held", 5'b00110);
      lit_sb("rst_sb_clear", 16'h0000);
      tick(); reset = 1'b0; #1;
      lit("rst_idle", 5'b00010);

      // Randomized phase
      for (int c = 0; c < 4000; c++) begin
         tick();
         reset        = ($urandom_range(0, 99) < 2);
         branch_taken = ($urandom_range(0, 99) < 8);
         d_valid      = ($urandom_range(0, 99) < 80);
         case ($urandom_range(0, 5))
            0:       d_opcode = OP_NOP;
            1:       d_opcode = OP_JMP;
            2:       d_opcode = OP_MUL;
            default: d_opcode = 5'($urandom_range(0, 31));
         endcase
         d_dest   = 4'($urandom_range(0, 15));
         d_s1     = 4'($urandom_range(0, 7));
         d_s2     = 4'($urandom_range(0, 7));
         wb_valid = ($urandom_range(0, 99) < 50);
         cand.delete();
         for (int r = 0; r < 16; r++) if (pend[r]) cand.push_back(r);
         if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            wb_dest = 4'(cand[$urandom_range(0, cand.size() - 1)]);
         else
            wb_dest = 4'($urandom_range(0, 15));
      end
      tick();
      #6;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the four-stage pipelined controller (fetch, decode, execute, writeback). It sits beside the decode stage register and decides each cycle whether the decoded instruction issues into execute, stalls, or is flushed. It keeps a 16-entry register scoreboard for RAW/WAW hazards, sequences multi-cycle MUL occupancy of execute, and applies the two-cycle flush after a taken branch.

## Interface
Parameters:
- OP_NOP, 5'h00, opcode of the no-op; never writes a register, never hazards.
- OP_JMP, 5'h1F, jump opcode; reads s1/s2, writes no register.
- OP_MUL, 5'h0A, multi-cycle multiply opcode.
- MUL_LAT, 4, execute cycles occupied by MUL (legal range 2..15).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- d_valid  in  1  decode register holds a valid instruction.
- d_opcode  in  5  decoded opcode.
- d_dest  in  4  destination register.
- d_s1  in  4  source register 1.
- d_s2  in  4  source register 2.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_dest  in  4  register retired.
- branch_taken  in  1  execute resolved a taken branch/jump this cycle.
- issue  out  1  decode instruction moves into execute at this edge.
- stall_fd  out  1  fetch and decode registers hold their contents.
- flush_fd  out  1  fetch and decode registers load NOP.
- bubble_x  out  1  execute register loads NOP.
- x_hold  out  1  execute register holds (MUL in progress).
- sb_pending  out  16  scoreboard; bit r set = write to r outstanding.

## Operation
- writes = d_opcode not in {OP_NOP, OP_JMP}; uses_src = d_opcode != OP_NOP.
- wb_clr = one-hot(wb_dest) gated by wb_valid; eff = sb_pending & ~wb_clr (same-cycle retire counts as free).
- hazard = d_valid & ((uses_src & (eff[d_s1] | eff[d_s2])) | (writes & eff[d_dest])).
- FSM states: IDLE, MUL, FLUSH. Priority: reset > branch_taken (IDLE only) > state > hazard.
- IDLE, branch_taken=1: issue=0, flush_fd=1, bubble_x=1, stall_fd=0; next FLUSH.
- IDLE, no branch, no hazard, d_valid: issue=1; if d_opcode==OP_MUL, load cnt=MUL_LAT-1, next MUL.
- IDLE, hazard: issue=0, stall_fd=1, bubble_x=1.
- IDLE, !d_valid: issue=0, bubble_x=1, stall_fd=0.
- MUL: issue=0, x_hold=1, stall_fd=d_valid, bubble_x=0; cnt decrements; at cnt==1 next IDLE (MUL occupies execute exactly MUL_LAT cycles including issue-following cycle count as specified in Timing). branch_taken ignored in MUL.
- FLUSH: flush_fd=1, bubble_x=1, issue=0; next IDLE unconditionally (branch_taken ignored).
- Scoreboard update: on issue & writes, set bit d_dest; on wb_valid, clear bit wb_dest; same register set and clear same cycle -> set wins. Scoreboard unaffected by flush.
- Outputs issue/stall_fd/flush_fd/bubble_x/x_hold are combinational from state and inputs; mutually: stall_fd and flush_fd never both 1; issue implies stall_fd=flush_fd=bubble_x=0.

## Timing
- reset=1 (sampled at edge): state IDLE, cnt=0, sb_pending=0. While reset is high, outputs forced issue=0, stall_fd=0, x_hold=0, flush_fd=1, bubble_x=1.
- Reset mid-MUL or mid-FLUSH: returns to IDLE next edge, scoreboard cleared.
- Hazard-free instruction issues in the same cycle d_valid is seen (zero added latency).
- MUL issued at edge T: x_hold=1 for cycles T+1..T+MUL_LAT-1; next issue possible at edge T+MUL_LAT.
- Branch seen in cycle T: flush in cycles T and T+1; earliest next issue at edge T+2.
- sb_pending reflects register state, updated one edge after issue/wb.

## Test plan
- RAW: issue write to r3; next cycle d_s1=3 -> issue=0, stall_fd=1, bubble_x=1 until wb_valid,wb_dest=3 cycle, where issue=1 same cycle.
- WAW and set/clear collision: wb retires r5 same cycle an instruction writing r5 issues -> sb_pending[5]=1 after edge.
- MUL (MUL_LAT=4): MUL issues at T -> x_hold=1 cycles T+1..T+3, next valid instruction issues at T+4, sb bit of MUL dest set at T+1.
- Branch: branch_taken in IDLE cycle T -> flush_fd=bubble_x=1 cycles T,T+1, issue=0; branch_taken during MUL -> no flush.
- NOP/JMP: OP_NOP with s1=pending reg issues; OP_JMP reading pending reg stalls, sets no scoreboard bit.
- Reset mid-MUL with sb_pending=16'h0028 -> next cycle IDLE, sb_pending=0, x_hold=0, flush_fd=bubble_x=1 while reset high.
